// File: rtl/mul4_tournament_sched_if.sv
// Bus between the tournament scheduler and the candidate side (operand
// fan-out, candidate mux select, selected outputs, score and winner reports).
interface mul4_tournament_sched_if #(
    parameter int CAND_W = 2
);
    logic              start;
    logic              busy;
    logic              done;
    logic [CAND_W-1:0] cand_sel;
    logic [15:0]       a1, a0, b1, b0;
    logic [15:0]       y3, y2, y1, y0;
    logic              fit_valid;
    logic [CAND_W-1:0] fit_idx;
    logic [6:0]        fit_val;
    logic [CAND_W-1:0] win_idx;
    logic [6:0]        win_fit;

    modport master (
        input  start, y3, y2, y1, y0,
        output busy, done, cand_sel, a1, a0, b1, b0,
               fit_valid, fit_idx, fit_val, win_idx, win_fit
    );

    modport slave (
        output start, y3, y2, y1, y0,
        input  busy, done, cand_sel, a1, a0, b1, b0,
               fit_valid, fit_idx, fit_val, win_idx, win_fit
    );
endinterface

// File: rtl/mul4_tournament_sched.sv
// Runs one tournament over NUM_CAND bit-sliced 2x2 multiplier candidates:
// select, settle, capture, score against the golden product, report winner.
module mul4_tournament_sched #(
    parameter int NUM_CAND   = 4,
    parameter int CAND_W     = $clog2(NUM_CAND),
    parameter int SETTLE_CYC = 1,
    parameter int EARLY_EXIT = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    mul4_tournament_sched_if.master      bus
);
    typedef enum logic [2:0] {S_IDLE, S_SEL, S_CAP, S_SCORE, S_DONE} state_t;

    // Index [3] is G3 ... [0] is G0; lane i holds a=i[3:2], b=i[1:0].
    localparam logic [3:0][15:0] GOLD = {16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0};

    state_t            r_state, w_next;
    logic [2:0]        r_settle;
    logic [CAND_W-1:0] r_cand_sel;
    logic [3:0][15:0]  r_cap;
    logic [CAND_W-1:0] r_best_idx, r_win_idx;
    logic [6:0]        r_best_fit, r_win_fit;
    logic [6:0]        w_fit;
    logic              w_last, w_upd;

    assign bus.a1 = 16'hFF00;
    assign bus.a0 = 16'hF0F0;
    assign bus.b1 = 16'hCCCC;
    assign bus.b0 = 16'hAAAA;

    // Count of lanes/words matching the golden product, from captured data only.
    always_comb begin
        w_fit = 7'd0;
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 16; b++)
                w_fit = w_fit + {6'd0, ~(r_cap[w][b] ^ GOLD[w][b])};
    end

    assign w_last = (r_cand_sel == CAND_W'(NUM_CAND - 1)) ||
                    ((EARLY_EXIT != 0) && (w_fit == 7'd64));
    // Strict > keeps the lower index on ties; candidate 0 always seeds best.
    assign w_upd  = (w_fit > r_best_fit) || (r_cand_sel == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_SEL;
            S_SEL:   if (r_settle == 3'(SETTLE_CYC - 1)) w_next = S_CAP;
            S_CAP:   w_next = S_SCORE;
            S_SCORE: w_next = w_last ? S_DONE : S_SEL;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle   <= '0;
            r_cand_sel <= '0;
            r_cap      <= '0;
            r_best_idx <= '0;
            r_best_fit <= '0;
            r_win_idx  <= '0;
            r_win_fit  <= '0;
        end else begin
            r_settle <= (r_state == S_SEL && w_next == S_SEL) ? r_settle + 3'd1 : 3'd0;
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_cand_sel <= '0;
                    r_best_fit <= '0;
                end
                S_CAP: r_cap <= {bus.y3, bus.y2, bus.y1, bus.y0};
                S_SCORE: begin
                    if (w_upd) begin
                        r_best_idx <= r_cand_sel;
                        r_best_fit <= w_fit;
                    end
                    if (w_last) begin
                        r_win_idx <= w_upd ? r_cand_sel : r_best_idx;
                        r_win_fit <= w_upd ? w_fit      : r_best_fit;
                    end else begin
                        r_cand_sel <= r_cand_sel + CAND_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy      = (r_state == S_SEL) || (r_state == S_CAP) || (r_state == S_SCORE);
        bus.done      = (r_state == S_DONE);
        bus.fit_valid = (r_state == S_SCORE);
        bus.fit_idx   = (r_state == S_SCORE) ? r_cand_sel : '0;
        bus.fit_val   = (r_state == S_SCORE) ? w_fit : 7'd0;
        bus.cand_sel  = r_cand_sel;
        bus.win_idx   = r_win_idx;
        bus.win_fit   = r_win_fit;
    end
endmodule

// File: doc/mul4_tournament_sched.md
Name: mul4_tournament_sched

Overview:
- Sequential scheduler that shares one evaluation slot among NUM_CAND combinational 2-bit x 2-bit multiplier candidates.
- Candidates are bit-sliced with 16 lanes per 16-bit word.
- Drives the exhaustive operand vectors, selects each candidate in turn through an external mux, and registers its y3..y0 outputs.
- Scores each candidate against the golden product and reports the tournament winner to the search controller.

Parameters:
- NUM_CAND, 4, number of candidates in one tournament (2..16).
- CAND_W, $clog2(NUM_CAND), width of candidate index.
- SETTLE_CYC, 1, cycles cand_sel is held before capture (1..7).
- EARLY_EXIT, 0, when 1 the tournament stops at the first candidate scoring 64.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin tournament; sampled only in IDLE.
- busy  out  1  high in SEL/CAP/SCORE.
- done  out  1  one-cycle pulse in DONE state.
- cand_sel  out  CAND_W  index of candidate driven onto y3..y0 by the external mux.
- a1, a0, b1, b0  out  16 each  operand vectors to all candidates.
- y3, y2, y1, y0  in  16 each  outputs of the selected candidate.
- fit_valid  out  1  one-cycle pulse per scored candidate.
- fit_idx  out  CAND_W  index of the candidate just scored.
- fit_val  out  7  fitness of the candidate just scored (0..64).
- win_idx  out  CAND_W  winning index; valid when done=1, held until next start.
- win_fit  out  7  winning fitness; same validity as win_idx.

Behaviour:
- Operand vectors are constants in every state, including reset: a1=16'hFF00, a0=16'hF0F0, b1=16'hCCCC, b0=16'hAAAA. Lane i therefore evaluates a=i[3:2], b=i[1:0].
- Golden product bit-slices: G3=16'h8000, G2=16'h4C00, G1=16'h6AC0, G0=16'hA0A0.
- Fitness = popcount(~(y3^G3)) + popcount(~(y2^G2)) + popcount(~(y1^G1)) + popcount(~(y0^G0)), range 0..64, 7 bits, no saturation needed.
- Reset values: state=IDLE; busy, done, fit_valid = 0; cand_sel, fit_idx, fit_val, win_idx, win_fit = 0.
- FSM states: IDLE, SEL, CAP, SCORE, DONE.
- IDLE: on start=1, set cand_sel=0 and best_fit=0, then go to SEL. Otherwise stay in IDLE.
- SEL: hold cand_sel for exactly SETTLE_CYC cycles, then go to CAP.
- CAP: register y3..y0 into capture registers, then go to SCORE.
- SCORE: compute fitness from the captured values only. Pulse fit_valid with fit_idx=cand_sel and fit_val=fitness.
  - Best update: if fitness > best_fit, or cand_sel==0, load best = {cand_sel, fitness}. Ties keep the lower index (strict >).
  - Transition: if cand_sel==NUM_CAND-1, or (EARLY_EXIT and fitness==64), go to DONE. Otherwise increment cand_sel and go to SEL.
- DONE: done=1 for one cycle and win_idx/win_fit drive best; then go to IDLE.
- Latency: each candidate costs SETTLE_CYC+2 cycles. With defaults, start accepted at cycle 0 gives done at cycle NUM_CAND*3+1 = 13.
- start asserted while not in IDLE (including DONE) is ignored, not queued.
- win_idx/win_fit hold their values through IDLE until the next tournament's DONE.
- cand_sel holds its last value in DONE and IDLE.
- y inputs are sampled only in CAP. Changes during SEL do not affect scoring.
- Reset mid-tournament: immediate return to IDLE with all outputs at reset values. No done pulse, and the partial best is discarded.

Test Plan:
- All candidates drive exactly G3..G0. Start, defaults -> fit_val=64 four times; done at cycle 13; win_idx=0, win_fit=64.
- Candidate outputs all zero. Start -> every fit_val=50 (64 minus 14 golden ones); tie resolves to win_idx=0, win_fit=50.
- Candidate 2 drives golden, others zero -> fit_val sequence 50, 50, 64, 50; win_idx=2, win_fit=64.
- Candidate 1 drives ~G on all words, candidate 3 golden, others zero -> fit_vals 50, 0, 50, 64; win_idx=3.
- EARLY_EXIT=1 with candidate 1 golden -> exactly two fit_valid pulses, done at cycle 7, win_idx=1.
- Pulse start while busy, then assert rst in the second SEL -> start ignored; after rst all outputs are 0, no done pulse, and a fresh start runs normally.
- Also with SETTLE_CYC=3: y inputs toggle during SEL and settle before CAP -> only settled values are scored.
